// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU MEM stage has priority, a starvation counter forces DMA beats through.
// Define DM_ARB_ABORT_EN to let dma_abort_i terminate a burst early.
module dm_port_arbiter #(
  parameter  int unsigned STARVE_MAX = 7,
  localparam int unsigned AW = 12,
  localparam int unsigned DW = 32,
  localparam int unsigned LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd_i,
  input  logic          cpu_wr_i,
  input  logic          cpu_wr_byte_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_stall_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [LW-1:0] dma_len_i,
  input  logic [DW-1:0] dma_wdata_i,
  input  logic          dma_abort_i,
  output logic          dma_beat_ack_o,
  output logic [DW-1:0] dma_rdata_o,
  output logic          dma_rvalid_o,
  output logic          dma_done_o,
  output logic          dma_busy_o,
  output logic          mem_we_o,
  output logic          mem_wr_byte_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_din_o,
  input  logic [DW-1:0] mem_dout_i
);

  localparam int unsigned      WAIT_W     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0] STARVE_LIM = WAIT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, LOAD, BURST, DONE} state_e;

  state_e            state_q;
  logic [AW-1:0]     a_q;
  logic [LW-1:0]     cnt_q;
  logic              we_q;
  logic [WAIT_W-1:0] wait_q;
  logic [DW-1:0]     rdata_q;
  logic              rvalid_q;

  logic cpu_access_c;
  logic dma_win_c;
  logic beat_c;
  logic abort_c;

`ifdef DM_ARB_ABORT_EN
  assign abort_c = dma_abort_i && ((state_q == LOAD) || (state_q == BURST));
`else
  logic unused_abort;
  assign unused_abort = dma_abort_i;
  assign abort_c      = 1'b0;
`endif

  // Port mux: the CPU owns the memory except in a cycle the DMA wins a beat.
  always_comb begin
    cpu_access_c   = cpu_rd_i | cpu_wr_i;
    dma_win_c      = !cpu_access_c || (wait_q >= STARVE_LIM);
    beat_c         = (state_q == BURST) && dma_win_c && !abort_c;
    cpu_stall_o    = cpu_access_c && beat_c;
    dma_beat_ack_o = beat_c;
    mem_we_o       = cpu_wr_i;
    mem_wr_byte_o  = cpu_wr_byte_i;
    mem_addr_o     = cpu_addr_i;
    mem_din_o      = cpu_wdata_i;
    if (beat_c) begin
      mem_we_o      = we_q;
      mem_wr_byte_o = 1'b0;
      mem_addr_o    = a_q;
      mem_din_o     = dma_wdata_i;
    end
  end

  assign dma_rdata_o  = rdata_q;
  assign dma_rvalid_o = rvalid_q;
  assign dma_done_o   = (state_q == DONE);
  assign dma_busy_o   = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wait_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= beat_c && !we_q;
      if (beat_c && !we_q) rdata_q <= mem_dout_i;
      case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (dma_req_i) begin
            a_q     <= {dma_addr_i[AW-1:2], 2'b00};
            cnt_q   <= dma_len_i;
            we_q    <= dma_we_i;
            state_q <= LOAD;
          end
        end
        LOAD: state_q <= abort_c ? DONE : BURST;
        BURST: begin
          if (abort_c) begin
            wait_q  <= '0;
            state_q <= DONE;
          end else if (beat_c) begin
            a_q    <= a_q + AW'(4);
            wait_q <= '0;
            if (cnt_q == '0) state_q <= DONE;
            else             cnt_q   <= cnt_q - LW'(1);
          end else if (wait_q < STARVE_LIM) begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        DONE: begin
          wait_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural 4 KB data memory.
module tb_dm_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr, cpu_wr_byte;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_abort;
  logic [11:0] dma_addr;
  logic [3:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_beat_ack, dma_rvalid, dma_done, dma_busy;
  logic [31:0] dma_rdata;
  logic        mem_we, mem_wr_byte;
  logic [11:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_init;
  logic [31:0] mem [0:1023];
  int nvec = 0;
  int nerr = 0;
  int k;
  logic win;

  always #5 clk = ~clk;

  dm_port_arbiter #(.STARVE_MAX(7)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr), .cpu_wr_byte_i(cpu_wr_byte),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_stall_o(cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_len_i(dma_len),
    .dma_wdata_i(dma_wdata), .dma_abort_i(dma_abort), .dma_beat_ack_o(dma_beat_ack),
    .dma_rdata_o(dma_rdata), .dma_rvalid_o(dma_rvalid), .dma_done_o(dma_done),
    .dma_busy_o(dma_busy), .mem_we_o(mem_we), .mem_wr_byte_o(mem_wr_byte),
    .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
  );

  // Memory model: word i initialised to 0xC000_0000 | i.
  assign mem_dout = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC000_0000 | 32'(i);
    end else if (mem_we) begin
      if (mem_wr_byte) mem[mem_addr[11:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_din[7:0];
      else             mem[mem_addr[11:2]] <= mem_din;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk12(input string tag, input logic [11:0] got, input logic [11:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic ack_e, input logic stall_e,
                          input logic we_e, input logic [11:0] addr_e);
    chk1({tag, "_ack"}, dma_beat_ack, ack_e);
    chk1({tag, "_stall"}, cpu_stall, stall_e);
    chk1({tag, "_we"}, mem_we, we_e);
    chk12({tag, "_addr"}, mem_addr, addr_e);
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_wr_byte = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_abort = 0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    tick;
    chk1("rst_stall", cpu_stall, 1'b0);
    chk1("rst_ack", dma_beat_ack, 1'b0);
    chk32("rst_rdata", dma_rdata, 32'h0);
    chk1("rst_rvalid", dma_rvalid, 1'b0);
    chk1("rst_done", dma_done, 1'b0);
    chk1("rst_busy", dma_busy, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    rst = 1'b0; mem_init = 1'b0;
    tick;

    // CPU byte store then load pass straight through when the DMA is idle
    cpu_wr = 1; cpu_wr_byte = 1; cpu_addr = 12'h011; cpu_wdata = 32'h1234_5655;
    settle;
    chk1("cpu_st_we", mem_we, 1'b1);
    chk1("cpu_st_byte", mem_wr_byte, 1'b1);
    chk12("cpu_st_addr", mem_addr, 12'h011);
    chk32("cpu_st_din", mem_din, 32'h1234_5655);
    tick;
    cpu_wr = 0; cpu_wr_byte = 0; cpu_rd = 1; cpu_addr = 12'h010;
    settle;
    chk32("cpu_ld_data", mem_dout, 32'hC000_5504);
    chk1("cpu_ld_stall", cpu_stall, 1'b0);
    tick;
    cpu_rd = 0;

    // DMA write burst, no CPU traffic
    dma_req = 1; dma_we = 1; dma_addr = 12'h100; dma_len = 4'd3; dma_wdata = 32'hA0;
    settle;
    chk1("t1_idle_ack", dma_beat_ack, 1'b0);
    chk1("t1_idle_busy", dma_busy, 1'b0);
    tick; settle;
    chk1("t1_load_busy", dma_busy, 1'b1);
    chk1("t1_load_ack", dma_beat_ack, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      dma_wdata = 32'hA0 + 32'(i);
      settle;
      chk_port("t1_beat", 1'b1, 1'b0, 1'b1, 12'h100 + 12'(4 * i));
      chk32("t1_din", mem_din, 32'hA0 + 32'(i));
      chk1("t1_byte", mem_wr_byte, 1'b0);
    end
    tick;
    dma_req = 0;
    settle;
    chk1("t1_done", dma_done, 1'b1);
    chk1("t1_done_ack", dma_beat_ack, 1'b0);
    chk1("t1_done_rvalid", dma_rvalid, 1'b0);
    tick; settle;
    chk1("t1_done_clr", dma_done, 1'b0);
    chk1("t1_idle_again", dma_busy, 1'b0);
    for (int i = 0; i < 4; i++) chk32("t1_mem", mem[10'h040 + 10'(i)], 32'hA0 + 32'(i));

    // DMA read-back of the same region
    dma_req = 1; dma_we = 0; dma_addr = 12'h100; dma_len = 4'd3;
    settle;
    tick; settle;
    for (int i = 0; i < 4; i++) begin
      tick; settle;
      chk_port("t2_beat", 1'b1, 1'b0, 1'b0, 12'h100 + 12'(4 * i));
      chk1("t2_rvalid", dma_rvalid, i != 0);
      if (i != 0) chk32("t2_rdata", dma_rdata, 32'hA0 + 32'(i - 1));
    end
    tick;
    dma_req = 0;
    settle;
    chk1("t2_done", dma_done, 1'b1);
    chk1("t2_last_rvalid", dma_rvalid, 1'b1);
    chk32("t2_last_rdata", dma_rdata, 32'hA3);
    tick; settle;
    chk1("t2_rvalid_clr", dma_rvalid, 1'b0);

    // CPU loads every cycle against a 2-beat read burst: DMA wins every 8th BURST cycle
    k = 0;
    dma_req = 1; dma_we = 0; dma_addr = 12'h200; dma_len = 4'd1;
    cpu_rd = 1; cpu_addr = 12'h040;
    settle;
    chk1("t3_idle_stall", cpu_stall, 1'b0);
    chk32("t3_idle_data", mem_dout, 32'hC000_0010);
    k = 1;
    tick;
    cpu_addr = 12'h044;
    settle;
    chk1("t3_load_stall", cpu_stall, 1'b0);
    chk32("t3_load_data", mem_dout, 32'hC000_0011);
    k = 2;
    for (int b = 1; b <= 16; b++) begin
      tick;
      cpu_addr = 12'h040 + 12'(4 * k);
      settle;
      win = (b == 8) || (b == 16);
      chk_port("t3_cyc", win, win, 1'b0,
               win ? ((b == 8) ? 12'h200 : 12'h204) : 12'h040 + 12'(4 * k));
      chk1("t3_rvalid", dma_rvalid, b == 9);
      if (b == 9) chk32("t3_rdata0", dma_rdata, 32'hC000_0080);
      if (!win) begin
        chk32("t3_cpu_data", mem_dout, 32'hC000_0010 + 32'(k));
        k++;
      end
    end
    tick;
    dma_req = 0; cpu_rd = 0;
    settle;
    chk1("t3_done", dma_done, 1'b1);
    chk1("t3_done_stall", cpu_stall, 1'b0);
    chk32("t3_rdata1", dma_rdata, 32'hC000_0081);
    tick;

    // Misaligned start at the top of memory wraps to 0
    dma_req = 1; dma_we = 0; dma_addr = 12'hFFE; dma_len = 4'd1;
    settle;
    tick; settle;
    tick; settle;
    chk_port("t4_beat0", 1'b1, 1'b0, 1'b0, 12'hFFC);
    tick; settle;
    chk_port("t4_beat1", 1'b1, 1'b0, 1'b0, 12'h000);
    chk32("t4_rdata0", dma_rdata, 32'hC000_03FF);
    tick;
    dma_req = 0;
    settle;
    chk1("t4_done", dma_done, 1'b1);
    chk32("t4_rdata1", dma_rdata, 32'hC000_0000);
    tick;

    // Reset asserted during the second beat of a 6-beat write
    dma_req = 1; dma_we = 1; dma_addr = 12'h300; dma_len = 4'd5; dma_wdata = 32'hD0;
    settle;
    tick; settle;
    tick; settle;
    chk_port("t5_beat0", 1'b1, 1'b0, 1'b1, 12'h300);
    tick;
    dma_wdata = 32'hD1;
    settle;
    chk_port("t5_beat1", 1'b1, 1'b0, 1'b1, 12'h304);
    rst = 1; dma_req = 0;
    #1;
    chk1("t5_rst_ack", dma_beat_ack, 1'b0);
    chk1("t5_rst_busy", dma_busy, 1'b0);
    chk1("t5_rst_we", mem_we, 1'b0);
    chk1("t5_rst_done", dma_done, 1'b0);
    chk1("t5_rst_rvalid", dma_rvalid, 1'b0);
    chk32("t5_rst_rdata", dma_rdata, 32'h0);
    tick;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      settle;
      chk1("t5_no_done", dma_done, 1'b0);
      chk1("t5_no_busy", dma_busy, 1'b0);
      tick;
    end
    chk32("t5_mem0", mem[10'h0C0], 32'hD0);
    chk32("t5_mem1", mem[10'h0C1], 32'hC000_00C1);
    dma_req = 1; dma_we = 1; dma_addr = 12'h400; dma_len = 4'd0; dma_wdata = 32'hF0;
    settle;
    tick; settle;
    tick; settle;
    chk_port("t5_fresh", 1'b1, 1'b0, 1'b1, 12'h400);
    tick;
    dma_req = 0;
    settle;
    chk1("t5_fresh_done", dma_done, 1'b1);
    tick; settle;
    chk32("t5_fresh_mem", mem[10'h100], 32'hF0);

    // dma_abort on the second beat of a 4-beat write
    dma_req = 1; dma_we = 1; dma_addr = 12'h500; dma_len = 4'd3; dma_wdata = 32'hE0;
    settle;
    tick; settle;
    tick; settle;
    chk_port("t6_beat0", 1'b1, 1'b0, 1'b1, 12'h500);
    tick;
    dma_wdata = 32'hE1; dma_abort = 1;
    settle;
`ifdef DM_ARB_ABORT_EN
    chk1("t6_abort_ack", dma_beat_ack, 1'b0);
    chk1("t6_abort_we", mem_we, 1'b0);
    tick;
    dma_abort = 0; dma_req = 0;
    settle;
    chk1("t6_done", dma_done, 1'b1);
    chk1("t6_done_ack", dma_beat_ack, 1'b0);
    tick; settle;
    chk1("t6_done_clr", dma_done, 1'b0);
    chk1("t6_idle", dma_busy, 1'b0);
    chk32("t6_mem0", mem[10'h140], 32'hE0);
    chk32("t6_mem1", mem[10'h141], 32'hC000_0141);
`else
    chk_port("t6_beat1", 1'b1, 1'b0, 1'b1, 12'h504);
    tick;
    dma_abort = 0; dma_wdata = 32'hE2;
    settle;
    chk_port("t6_beat2", 1'b1, 1'b0, 1'b1, 12'h508);
    tick;
    dma_wdata = 32'hE3;
    settle;
    chk_port("t6_beat3", 1'b1, 1'b0, 1'b1, 12'h50C);
    tick;
    dma_req = 0;
    settle;
    chk1("t6_done", dma_done, 1'b1);
    tick; settle;
    chk32("t6_mem1", mem[10'h141], 32'hE1);
    chk32("t6_mem3", mem[10'h143], 32'hE3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
